// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive control stage.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        STOP_CHK,
        LOAD
    } rx_state_t;

    localparam int DATA_MIN        = 5;
    localparam int SYNC_STAGES_MAX = 3;

    // Out-of-range frame sizes fall back to the full buffer width.
    function automatic logic [3:0] eff_size(input logic [3:0] size, input int data_w);
        if (int'(size) < DATA_MIN || int'(size) > data_w) begin
            return 4'(data_w);
        end
        return size;
    endfunction

endpackage

// File: rtl/rx_sync_edge.sv
// Serial-line synchronizer with a falling-edge (start bit) detector.
// Both the chain and the edge register reset to the idle-high line level.
module rx_sync_edge
    import uart_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
)
(
    input  logic clk,
    input  logic rst,
    input  logic serial_i,
    output logic sync_bit_o,
    output logic start_edge_o
);

    localparam int STAGES = (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX :
                            (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], serial_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_bit_o   = sync_q[STAGES-1];
    assign start_edge_o = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: start detection, LSB-first shift-in, stop check and
// output buffer with ready/read handshake. Optional parity via UART_RX_PARITY_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | line idle, waiting for a 1->0 start edge
//   RECEIVE  | timer running; shift a sample in on each shift_enable
//   STOP_CHK | inspect stop bit (and parity); framing error returns to IDLE
//   LOAD     | copy right-aligned data into the buffer, raise data_ready
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    input  logic [3:0]        data_size,
    input  logic              shift_enable,
    input  logic              packet_done,
    input  logic              data_read,
`ifdef UART_RX_PARITY_EN
    input  logic              parity_odd,
    output logic              parity_error,
`endif
    output logic              enable_timer,
    output logic [3:0]        timer_data_size,
    output logic [DATA_W-1:0] rx_data,
    output logic              data_ready,
    output logic              framing_error,
    output logic              overrun_error
);

`ifdef UART_RX_PARITY_EN
    localparam int          SR_W     = DATA_W + 2;
    localparam logic [3:0]  PAR_BITS = 4'd1;
`else
    localparam int          SR_W     = DATA_W + 1;
    localparam logic [3:0]  PAR_BITS = 4'd0;
`endif

    rx_state_t         state_q, state_d;
    logic [SR_W-1:0]   shift_q, shift_d;
    logic [3:0]        size_q, size_d;
    logic [3:0]        tsize_q, tsize_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              ready_q, ready_d;
    logic              ferr_q, ferr_d;
    logic              ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic              perr_q, perr_d;
`endif

    logic              sync_bit;
    logic              start_edge;
    logic [DATA_W-1:0] data_aligned;

    rx_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk          (clk),
        .rst          (rst),
        .serial_i     (serial_in),
        .sync_bit_o   (sync_bit),
        .start_edge_o (start_edge)
    );

    // Data bits land at the top of the low DATA_W bits; shift down to right-align.
    assign data_aligned = shift_q[DATA_W-1:0] >> (DATA_W - int'(size_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            size_q    <= '0;
            tsize_q   <= '0;
            rx_data_q <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            size_q    <= size_d;
            tsize_q   <= tsize_d;
            rx_data_q <= rx_data_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        size_d       = size_q;
        tsize_d      = tsize_q;
        rx_data_d    = rx_data_q;
        ready_d      = ready_q;
        ferr_d       = ferr_q;
        ovr_d        = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d       = perr_q;
`endif
        enable_timer = 1'b0;

        if (data_read) begin
            ready_d = 1'b0;
            ovr_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b0;
`endif
                    size_d  = eff_size(data_size, DATA_W);
                    tsize_d = eff_size(data_size, DATA_W) + PAR_BITS;
                    shift_d = '0;
                    state_d = RECEIVE;
                end
            end
            RECEIVE: begin
                enable_timer = 1'b1;
                if (shift_enable) begin
                    shift_d = {sync_bit, shift_q[SR_W-1:1]};
                end
                if (packet_done) begin
                    state_d = STOP_CHK;
                end
            end
            STOP_CHK: begin
`ifdef UART_RX_PARITY_EN
                if ((^{data_aligned, shift_q[DATA_W]}) != parity_odd) begin
                    perr_d = 1'b1;
                end
`endif
                if (shift_q[SR_W-1]) begin
                    state_d = LOAD;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            LOAD: begin
                rx_data_d = data_aligned;
                // A read arriving with the load acknowledges the old byte, so no overrun.
                if (ready_q && !data_read) begin
                    ovr_d = 1'b1;
                end
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign timer_data_size = tsize_q;
    assign rx_data         = rx_data_q;
    assign data_ready      = ready_q;
    assign framing_error   = ferr_q;
    assign overrun_error   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error    = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table-driven frames, hand-written corner sequences and
// random frames checked against a frame-level reference model.
module tb_uart_rx_ctrl;

    localparam int BIT = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic [3:0] data_size;
    logic       shift_enable;
    logic       packet_done;
    logic       data_read;
    logic       enable_timer;
    logic [3:0] timer_data_size;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd;
    logic       parity_error;
    logic       frame_pbit;
    logic       m_pe;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] m_rx;
    logic       m_ready, m_fe, m_ov;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_in),
        .data_size       (data_size),
        .shift_enable    (shift_enable),
        .packet_done     (packet_done),
        .data_read       (data_read),
`ifdef UART_RX_PARITY_EN
        .parity_odd      (parity_odd),
        .parity_error    (parity_error),
`endif
        .enable_timer    (enable_timer),
        .timer_data_size (timer_data_size),
        .rx_data         (rx_data),
        .data_ready      (data_ready),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] size;
        logic       stop;
        logic       read_after;
        logic [7:0] exp_rx;
        logic       exp_ready;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_rx_data"}, rx_data, m_rx);
        check({tag, "_data_ready"}, data_ready, m_ready);
        check({tag, "_framing_error"}, framing_error, m_fe);
        check({tag, "_overrun_error"}, overrun_error, m_ov);
`ifdef UART_RX_PARITY_EN
        check({tag, "_parity_error"}, parity_error, m_pe);
`endif
    endtask

    task automatic bit_strobe();
        repeat (BIT/2) tick();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        repeat (BIT/2 - 1) tick();
    endtask

    task automatic do_read();
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_ready = 1'b0;
        m_ov    = 1'b0;
        check("read_clears_ready", data_ready, m_ready);
        check("read_clears_overrun", overrun_error, m_ov);
    endtask

    // One whole frame driven by an ideal bit timer; the model is updated
    // from the frame contents once the frame has been delivered.
    task automatic send_frame(input logic [7:0] data, input logic [3:0] sz, input logic stop,
                              input logic read_at_load, input int hold_low);
        int         eff;
        int         mask;
        logic [7:0] exp_rx;
        eff    = (sz >= 4'd5 && sz <= 4'd8) ? int'(sz) : 8;
        mask   = (1 << eff) - 1;
        exp_rx = data & mask[7:0];
        data_size = sz;
        serial_in = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < eff; i++) begin
            serial_in = data[i];
            bit_strobe();
            if (i == 0) begin
                check("enable_timer_in_frame", enable_timer, 1);
                check("timer_data_size", timer_data_size, eff + PAR);
            end
        end
`ifdef UART_RX_PARITY_EN
        serial_in = frame_pbit;
        bit_strobe();
`endif
        serial_in = stop;
        repeat (BIT/2) tick();
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
        packet_done  = 1'b1;
        tick();
        packet_done  = 1'b0;
        tick();
        check("pre_load_ready", data_ready, m_ready);
        check("pre_load_rx", rx_data, m_rx);
        data_read = read_at_load;
        tick();
        data_read = 1'b0;

        m_fe = !stop;
        if (stop) begin
            if (read_at_load) m_ov = 1'b0;
            else if (m_ready) m_ov = 1'b1;
            m_ready = 1'b1;
            m_rx    = exp_rx;
        end else if (read_at_load) begin
            m_ready = 1'b0;
            m_ov    = 1'b0;
        end
`ifdef UART_RX_PARITY_EN
        m_pe = ((^exp_rx) ^ frame_pbit) != parity_odd;
`endif
        check("enable_timer_after", enable_timer, 0);
        check_model("frame");

        if (hold_low > 0) begin
            repeat (hold_low) tick();
            check("no_retrigger_low_line", enable_timer, 0);
        end
        serial_in = 1'b1;
        repeat (BIT) tick();
    endtask

    initial begin
        rst = 1'b1; serial_in = 1'b1; data_size = 4'd8;
        shift_enable = 1'b0; packet_done = 1'b0; data_read = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0; frame_pbit = 1'b0; m_pe = 1'b0;
`endif
        m_rx = '0; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;

        vecs[0] = '{8'hA5, 4'd8,  1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hF6, 4'd5,  1'b1, 1'b0, 8'h16, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 4'd8,  1'b0, 1'b0, 8'h16, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h11, 4'd8,  1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h22, 4'd8,  1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h7E, 4'd3,  1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hC3, 4'd12, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        repeat (BIT) tick();
        check("reset_enable_timer", enable_timer, 0);
        check("reset_timer_data_size", timer_data_size, 0);
        check_model("reset");

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].size, vecs[v].stop, 1'b0, 0);
            check("tbl_rx_data", rx_data, vecs[v].exp_rx);
            check("tbl_data_ready", data_ready, vecs[v].exp_ready);
            check("tbl_framing_error", framing_error, vecs[v].exp_fe);
            check("tbl_overrun_error", overrun_error, vecs[v].exp_ov);
            if (vecs[v].read_after) do_read();
        end

        // Framing error with the line left low must not restart reception.
        send_frame(8'h3C, 4'd8, 1'b0, 1'b0, 30);
        check("held_low_framing", framing_error, 1);

        // Read coinciding with a load: the load wins, no overrun.
        send_frame(8'h33, 4'd8, 1'b1, 1'b0, 0);
        send_frame(8'h5A, 4'd8, 1'b1, 1'b1, 0);
        check("load_vs_read_ready", data_ready, 1);
        check("load_vs_read_overrun", overrun_error, 0);
        check("load_vs_read_rx", rx_data, 8'h5A);

        // Reset in the middle of the data bits.
        data_size = 4'd8;
        serial_in = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 3; i++) begin
            serial_in = i[0] ? 1'b0 : 1'b1;
            bit_strobe();
        end
        rst = 1'b1; serial_in = 1'b1;
        tick();
        rst = 1'b0;
        m_rx = '0; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
`ifdef UART_RX_PARITY_EN
        m_pe = 1'b0;
`endif
        check("midrst_enable_timer", enable_timer, 0);
        check("midrst_timer_data_size", timer_data_size, 0);
        check_model("midrst");
        repeat (2*BIT) tick();
        send_frame(8'h7E, 4'd8, 1'b1, 1'b0, 0);
        check("after_rst_rx", rx_data, 8'h7E);
        do_read();

`ifdef UART_RX_PARITY_EN
        parity_odd = 1'b0;
        frame_pbit = 1'b0;
        send_frame(8'h07, 4'd8, 1'b1, 1'b0, 0);
        check("parity_bad", parity_error, 1);
        check("parity_bad_rx", rx_data, 8'h07);
        frame_pbit = 1'b1;
        send_frame(8'h07, 4'd8, 1'b1, 1'b1, 0);
        check("parity_good", parity_error, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic [3:0] s;
            logic       st;
            d  = 8'($urandom);
            s  = 4'($urandom_range(0, 15));
            st = ($urandom_range(0, 5) != 0);
`ifdef UART_RX_PARITY_EN
            parity_odd = 1'($urandom);
            frame_pbit = 1'($urandom);
`endif
            send_frame(d, s, st, ($urandom_range(0, 7) == 0), 0);
            if ($urandom_range(0, 2) == 0) do_read();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
